// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the board RGB LED: one requester at a time, bounded slot, registered drive.
// Define LED_ARB_GAP_EN to insert GAP_CYCLES dark cycles between owners.
module rgb_led_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SLOT_CYCLES = 6000000,
  parameter int GAP_CYCLES  = 1200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   red,
  output logic                   green,
  output logic                   blue
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

`ifdef LED_ARB_GAP_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
`endif

  state_t              state_r;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       owner_r;
  logic [CW-1:0]       cnt_r;

  logic [NUM_REQ-1:0]  owner_onehot_s;
  logic [2:0]          owner_color_s;
  logic                owner_req_s;
  logic                others_s;
  logic                expiry_s;
  logic                end_tenure_s;
  logic [IW-1:0]       next_ptr_s;
  logic                win_hit_s;
  logic [IW-1:0]       win_idx_s;

  // First set request at or after base, wrapping; MSB of the result flags a hit.
  function automatic logic [IW:0] rr_search(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      base);
    logic [IW:0]   res;
    logic [IW-1:0] sel;
    int            idx;
    res = {(IW+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      sel = IW'(idx);
      if (r[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Decode the current owner into a one-hot mask and its live colour.
  always_comb begin
    owner_onehot_s = {NUM_REQ{1'b0}};
    owner_color_s  = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_onehot_s[i] = (owner_r == IW'(i));
      owner_color_s     = owner_color_s | (color[3*i +: 3] & {3{owner_onehot_s[i]}});
    end
  end

  // Tenure bookkeeping: who wants the LED, slot expiry, next pointer.
  always_comb begin
    owner_req_s  = |(req & owner_onehot_s);
    others_s     = |(req & ~owner_onehot_s);
    expiry_s     = (cnt_r == SLOT_LAST);
    end_tenure_s = !owner_req_s || (expiry_s && others_s);
    if (owner_r == IW'(NUM_REQ - 1)) begin
      next_ptr_s = {IW{1'b0}};
    end else begin
      next_ptr_s = owner_r + IW'(1);
    end
  end

  // Arbitration from the committed pointer, used when leaving IDLE.
  always_comb begin
    {win_hit_s, win_idx_s} = rr_search(req, ptr_r);
  end

`ifndef LED_ARB_GAP_EN
  logic          nxt_hit_s;
  logic [IW-1:0] nxt_idx_s;

  // Arbitration from the post-tenure pointer for gapless handoff.
  always_comb begin
    {nxt_hit_s, nxt_idx_s} = rr_search(req, next_ptr_s);
  end
`endif

  // Arbiter FSM with registered LED/grant outputs derived from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {IW{1'b0}};
      owner_r <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      grant   <= {NUM_REQ{1'b0}};
      busy    <= 1'b0;
      red     <= 1'b0;
      green   <= 1'b0;
      blue    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (win_hit_s) begin
            owner_r <= win_idx_s;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (end_tenure_s) begin
            ptr_r <= next_ptr_s;
            cnt_r <= {CW{1'b0}};
`ifdef LED_ARB_GAP_EN
            state_r <= ST_GAP;
`else
            if (nxt_hit_s) begin
              owner_r <= nxt_idx_s;
              state_r <= ST_GRANT;
            end else begin
              state_r <= ST_IDLE;
            end
`endif
          end else if (expiry_s) begin
            // Nobody else is waiting: the owner simply starts a new slot.
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`ifdef LED_ARB_GAP_EN
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase

      if (state_r == ST_GRANT) begin
        grant               <= owner_onehot_s;
        busy                <= 1'b1;
        {red, green, blue}  <= owner_color_s;
      end else begin
        grant               <= {NUM_REQ{1'b0}};
        busy                <= 1'b0;
        {red, green, blue}  <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed self-checking bench for rgb_led_arbiter (NUM_REQ=4, SLOT=8, GAP=2).
// Expectations follow LED_ARB_GAP_EN when defined, gapless handoff otherwise.
module tb_rgb_led_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] color;
  logic [3:0]  grant;
  logic        busy, red, green, blue;
  logic [7:0]  obs;
  int          checks = 0;
  int          errors = 0;

  localparam logic [11:0] COLOR_TABLE = {3'b011, 3'b110, 3'b010, 3'b100};

  rgb_led_arbiter #(
    .NUM_REQ     (4),
    .SLOT_CYCLES (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .color (color),
    .grant (grant),
    .busy  (busy),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always #5 clk = ~clk;

  assign obs = {grant, busy, red, green, blue};

  function automatic logic [2:0] exp_rgb(input logic [3:0] g);
    case (g)
      4'b0001: return 3'b100;
      4'b0010: return 3'b010;
      4'b0100: return 3'b110;
      4'b1000: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Sample n consecutive cycles on the falling edge against one owner.
  task automatic expect_run(input string tag, input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, obs, {g, (g != 4'b0000), exp_rgb(g)});
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    color = 12'b000_000_000_100;
    #2 rst_n = 1'b0;
    #1 check("reset_async", obs, 8'b0000_0_000);

    // Single requester: latency, long hold across slot restarts, live colour, release.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0001;
    @(negedge clk);
    check("t1_latency", obs, 8'b0000_0_000);
    @(negedge clk);
    check("t1_grant", obs, 8'b0001_1_100);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("t1_hold", obs, 8'b0001_1_100);
    end
    color[2:0] = 3'b001;
    @(negedge clk);
    check("t1_color", obs, 8'b0001_1_001);
    req = 4'b0000;
    @(negedge clk);
    check("t1_release_edge", obs, 8'b0001_1_001);
    @(negedge clk);
    check("t1_released", obs, 8'b0000_0_000);

    // Two requesters alternating.
    color = COLOR_TABLE;
    do_reset(4'b0101);
    expect_run("t2_start", 4'b0000, 1);
    expect_run("t2_own0", 4'b0001, 8);
`ifdef LED_ARB_GAP_EN
    expect_run("t2_gap_a", 4'b0000, 3);
    expect_run("t2_own2", 4'b0100, 8);
    expect_run("t2_gap_b", 4'b0000, 3);
`else
    expect_run("t2_own2", 4'b0100, 8);
`endif
    expect_run("t2_back0", 4'b0001, 1);

    // All four requesters rotate with wrap back to 0.
    do_reset(4'b1111);
    expect_run("t3_start", 4'b0000, 1);
    expect_run("t3_own0", 4'b0001, 8);
`ifdef LED_ARB_GAP_EN
    expect_run("t3_gap0", 4'b0000, 3);
    expect_run("t3_own1", 4'b0010, 8);
    expect_run("t3_gap1", 4'b0000, 3);
    expect_run("t3_own2", 4'b0100, 8);
    expect_run("t3_gap2", 4'b0000, 3);
    expect_run("t3_own3", 4'b1000, 8);
    expect_run("t3_gap3", 4'b0000, 3);
`else
    expect_run("t3_own1", 4'b0010, 8);
    expect_run("t3_own2", 4'b0100, 8);
    expect_run("t3_own3", 4'b1000, 8);
`endif
    expect_run("t3_wrap0", 4'b0001, 1);

    // Owner 0 drops at slot count 3 while requester 1 waits.
    do_reset(4'b0011);
    expect_run("t4_start", 4'b0000, 1);
    expect_run("t4_own0", 4'b0001, 3);
    req = 4'b0010;
    expect_run("t4_drop_edge", 4'b0001, 1);
`ifdef LED_ARB_GAP_EN
    expect_run("t4_gap_a", 4'b0000, 1);
    req = 4'b0011;
    expect_run("t4_gap_b", 4'b0000, 2);
`else
    req = 4'b0011;
`endif
    expect_run("t4_own1", 4'b0010, 8);
`ifdef LED_ARB_GAP_EN
    expect_run("t4_gap_c", 4'b0000, 3);
`endif
    expect_run("t4_back0", 4'b0001, 2);

    // Asynchronous reset between edges, then restart from pointer 0.
    #2 rst_n = 1'b0;
    #1 check("t5_async", obs, 8'b0000_0_000);
    @(negedge clk);
    req   = 4'b1000;
    rst_n = 1'b1;
    expect_run("t5_start", 4'b0000, 1);
    expect_run("t5_own3", 4'b1000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Round-robin arbiter that shares the single board RGB LED among up to `NUM_REQ` independent requesters (status FSMs, heartbeat, error indicators). Each requester presents a request and a 3-bit colour; the arbiter grants one owner at a time for a bounded time slot, drives the LED with the owner's colour, and optionally inserts a dark gap between owners so that handoffs are visible. It sits between the per-feature LED FSMs and the `red`/`green`/`blue` pins.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `SLOT_CYCLES`, 6000000, maximum cycles an owner holds the LED while others wait (0.5 s at 12 MHz; ≥2)
- `GAP_CYCLES`, 1200000, dark cycles between owners (0.1 s; ≥1; used only with `LED_ARB_GAP_EN`)

- `clk`  input  1  system clock, 12 MHz
- `rst_n`  input  1  asynchronous active-low reset
- `req`  input  NUM_REQ  level request; bit i = requester i
- `color`  input  3*NUM_REQ  colour of requester i: `[3i+2]`=red, `[3i+1]`=green, `[3i]`=blue
- `grant`  output  NUM_REQ  one-hot current owner, 0 when none
- `busy`  output  1  high when an owner holds the LED
- `red`, `green`, `blue`  output  1 each  registered LED drive

## Operation
- States: IDLE, GRANT, GAP (GAP exists only with `LED_ARB_GAP_EN`).
- Round-robin pointer `ptr` (reset 0): search `req` from index `ptr` upward with wrap; first set bit wins.
- IDLE: LED off, `grant`=0. If any `req` is set, latch the winner as owner, clear slot counter, go to GRANT.
- GRANT: slot counter increments every cycle from 0; expiry when count == SLOT_CYCLES-1.
  - `req[owner]` low → end of tenure.
  - Expiry with any other `req` bit set → end of tenure (preemption).
  - Expiry with no other requester → counter restarts at 0; owner keeps LED indefinitely.
  - Owner drop and expiry in the same cycle → treated as drop (identical result).
- End of tenure: `ptr` ← (owner+1) mod NUM_REQ; go to GAP (macro defined) or handoff (see Configuration).
- GAP: LED off, `grant`=0, counter counts 0..GAP_CYCLES-1, then IDLE. Requests during GAP are not latched; they arbitrate in IDLE.
- Colour is sampled live from `color` of the owner every cycle while in GRANT; colour changes propagate with output latency.
- Counter width: `$clog2(max(SLOT_CYCLES, GAP_CYCLES))`; never exceeds its terminal value.
- A requester whose bit is outside `[NUM_REQ-1:0]` does not exist; no range errors are possible.

## Timing
- Reset (async, immediate, no clock needed): state IDLE, `ptr`=0, counter=0, `grant`=0, `busy`=0, `red`=`green`=`blue`=0.
- All outputs are registered from the current state/owner: they change one edge after the state changes.
- Request latency: `req` high at edge E0 → state GRANT after E0 → `grant`/`busy`/LED valid after E1.
- Release latency: `req[owner]` low at edge E0 → state leaves GRANT after E0 → outputs drop after E1.
- Preemptive tenure length: exactly SLOT_CYCLES cycles of `grant` high.
- Gap length: exactly GAP_CYCLES cycles of `grant`=0 and LED off between owners, plus one IDLE cycle before the next grant.
- Reset mid-tenure: outputs go to 0 asynchronously; after `rst_n` rises, arbitration restarts from `ptr`=0.

## Configuration
- `LED_ARB_GAP_EN` defined: GAP state compiled in; every end of tenure enters GAP for GAP_CYCLES.
- Undefined: no GAP state; at end of tenure the arbiter searches from the updated `ptr` in the same cycle: if another requester is pending, it goes directly to GRANT with the new owner and a cleared counter (`grant` switches one-hot to one-hot on a single edge, no dark cycle); otherwise it goes to IDLE. `GAP_CYCLES` is ignored.

## Test plan
Bench parameters: NUM_REQ=4, SLOT_CYCLES=8, GAP_CYCLES=2, macro defined unless noted.
- `req`=0001, `color[2:0]`=100 → `grant`=0001, `busy`=1, `red`=1 after the second edge; held for 40 cycles with slot restarts; no glitch on `grant`.
- `req`=0101 from reset → `grant`=0001 for 8 cycles, 2 dark cycles, 1 IDLE cycle, `grant`=0100 for 8 cycles, then back to 0001.
- `req`=1111 → grant sequence 0001, 0010, 0100, 1000, 0001, each exactly 8 cycles; colours follow the owner.
- Owner 0 drops `req` at slot count 3 with `req[1]` high → `grant` clears one edge later; gap of 2; `grant`=0010 with a fresh 8-cycle slot.
- `rst_n` pulled low mid-GRANT between clock edges → all outputs 0 immediately; after release with `req`=1000 → `grant`=1000 two edges later.
- Macro undefined, `req`=0101 → `grant` goes 0001→0100 on one edge after 8 cycles, LED never dark between owners.
